// File: rtl/jtag_reg_access.sv
// Debug-side GPR access controller: halts the core, accesses the regfile through its
// JTAG port without colliding with EX writeback, and read-back-verifies every write.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | ready for a command, core not held
// HALT_WAIT | halt requested, waiting for halted_i or timeout
// ACCESS    | read capture, or write pulse once core_we_i is low
// VERIFY    | read back the written register and compare
// RESP      | response presented until resp_ready_i
module jtag_reg_access #(
   parameter int unsigned HALT_TIMEOUT = 255,
   parameter int unsigned CNT_W        = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_write_i,
   input  logic [4:0]  req_addr_i,
   input  logic [31:0] req_data_i,
   output logic        resp_valid_o,
   input  logic        resp_ready_i,
   output logic [31:0] resp_data_o,
   output logic        resp_err_o,
   output logic        halt_req_o,
   input  logic        halted_i,
   input  logic        core_we_i,
   output logic        jtag_we_o,
   output logic [4:0]  jtag_addr_o,
   output logic [31:0] jtag_wdata_o,
   input  logic [31:0] jtag_rdata_i
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_HALT_WAIT = 3'd1,
      S_ACCESS    = 3'd2,
      S_VERIFY    = 3'd3,
      S_RESP      = 3'd4
   } state_e;

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(HALT_TIMEOUT);

   state_e            state_q, state_d;
   logic              wr_q, wr_d;
   logic [4:0]        addr_q, addr_d;
   logic [31:0]       data_q, data_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;

   logic [CNT_W-1:0]  cnt_inc;
   logic              addr_nz;

   assign cnt_inc = cnt_q + CNT_W'(1);
   assign addr_nz = |addr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               wr_d    = req_write_i;
               addr_d  = req_addr_i;
               data_d  = req_data_i;
               cnt_d   = '0;
               rdata_d = '0;
               err_d   = 1'b0;
               state_d = S_HALT_WAIT;
            end
         end
         S_HALT_WAIT: begin
            // halted_i is checked first so it wins over a simultaneous timeout
            if (halted_i) begin
               state_d = S_ACCESS;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == TIMEOUT_C) begin
                  rdata_d = '0;
                  err_d   = 1'b1;
                  state_d = S_RESP;
               end
            end
         end
         S_ACCESS: begin
            if (!wr_q) begin
               rdata_d = addr_nz ? jtag_rdata_i : 32'h0;
               err_d   = 1'b0;
               state_d = S_RESP;
            end else if (!addr_nz) begin
               rdata_d = '0;
               err_d   = 1'b0;
               state_d = S_RESP;
            end else if (!core_we_i) begin
               state_d = S_VERIFY;
            end
         end
         S_VERIFY: begin
            rdata_d = jtag_rdata_i;
            err_d   = (jtag_rdata_i != data_q);
            state_d = S_RESP;
         end
         S_RESP: begin
            if (resp_ready_i) begin
               rdata_d = '0;
               err_d   = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready_o  = 1'b0;
      halt_req_o   = 1'b0;
      resp_valid_o = 1'b0;
      jtag_we_o    = 1'b0;
      jtag_addr_o  = '0;
      jtag_wdata_o = '0;
      unique case (state_q)
         S_IDLE: begin
            req_ready_o = 1'b1;
         end
         S_HALT_WAIT: begin
            halt_req_o = 1'b1;
         end
         S_ACCESS: begin
            halt_req_o   = 1'b1;
            jtag_addr_o  = addr_q;
            jtag_wdata_o = data_q;
            // EX writeback owns the regfile port while core_we_i is high
            jtag_we_o    = wr_q && addr_nz && !core_we_i;
         end
         S_VERIFY: begin
            halt_req_o   = 1'b1;
            jtag_addr_o  = addr_q;
            jtag_wdata_o = data_q;
         end
         S_RESP: begin
            halt_req_o   = 1'b1;
            resp_valid_o = 1'b1;
         end
         default: begin
            req_ready_o = 1'b0;
         end
      endcase
   end

   assign resp_data_o = rdata_q;
   assign resp_err_o  = err_q;

endmodule

// File: doc/jtag_reg_access.md
Name: jtag_reg_access

Overview:
- Debug-side controller that drives the register file's JTAG access port: jtag_we, jtag_addr and write data out, read data back.
- Accepts single GPR read/write commands from the debug transport over a valid/ready handshake.
- Halts the core before each access, avoids collisions with the core's EX writeback, and read-back-verifies every write.
- Returns data and an error flag over a valid/ready response channel.

Parameters:
- HALT_TIMEOUT, 255: max cycles waiting for halted_i before aborting with error.
- CNT_W, 8: width of the halt-wait counter; must hold HALT_TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid_i  in  1  command valid
- req_ready_o  out  1  command accepted when valid&&ready
- req_write_i  in  1  1 = write GPR, 0 = read GPR
- req_addr_i  in  5  GPR index
- req_data_i  in  32  write data
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response consumed when valid&&ready
- resp_data_o  out  32  read data / write read-back
- resp_err_o  out  1  halt timeout or write-verify mismatch
- halt_req_o  out  1  request core halt
- halted_i  in  1  core is halted
- core_we_i  in  1  EX-stage regfile write enable (has priority at regfile)
- jtag_we_o  out  1  regfile JTAG write enable
- jtag_addr_o  out  5  regfile JTAG address
- jtag_wdata_o  out  32  regfile JTAG write data
- jtag_rdata_i  in  32  regfile JTAG read data (combinational from jtag_addr_o)

Behaviour:
- Reset (async, immediate): state IDLE; every output 0 except req_ready_o=1; latched cmd/addr/data/counter cleared. Reset mid-operation aborts the command; no response is issued and halt_req_o drops at once.
- States: IDLE, HALT_WAIT, ACCESS, VERIFY, RESP.
- IDLE:
  - req_ready_o=1, halt_req_o=0.
  - On req_valid_i: latch write/addr/data, clear counter, go to HALT_WAIT.
  - req_ready_o=0 in all other states.
- HALT_WAIT:
  - halt_req_o=1.
  - If halted_i, go to ACCESS.
  - Else counter increments. When counter==HALT_TIMEOUT, go to RESP with resp_err_o=1 and resp_data_o=0.
  - halted_i sampled in the same cycle the counter reaches the limit: halted_i wins.
- halt_req_o stays 1 from HALT_WAIT through RESP and drops on return to IDLE.
- jtag_addr_o = latched addr in ACCESS and VERIFY, 0 otherwise. jtag_wdata_o = latched data in the same states, 0 otherwise.
- ACCESS, write to x0: no write pulse; go to RESP with data 0, err 0.
- ACCESS, write to non-zero addr:
  - jtag_we_o = !core_we_i (combinational decode).
  - While core_we_i=1, stall in ACCESS; jtag_we_o stays 0.
  - In the first cycle with core_we_i=0, jtag_we_o=1 for exactly that one cycle, then go to VERIFY.
- ACCESS, read: capture jtag_rdata_i (0 for x0) into resp_data_o, err 0, go to RESP. Read takes one cycle in ACCESS regardless of core_we_i.
- VERIFY:
  - jtag_we_o=0.
  - Capture jtag_rdata_i into resp_data_o.
  - resp_err_o = (jtag_rdata_i != latched data); go to RESP.
- RESP:
  - resp_valid_o=1; resp_data_o and resp_err_o held stable until resp_ready_i.
  - On handshake: go to IDLE, resp_valid_o=0 next cycle.
  - No new command is accepted until then; one command outstanding at most.
- Latency, no stalls, halted_i already high:
  - Read: accept at cycle 0, resp_valid_o at cycle 3.
  - Write: accept at cycle 0, resp_valid_o at cycle 4.
- halted_i dropping after HALT_WAIT is ignored; the access proceeds.
- jtag_we_o is never asserted outside ACCESS and never for more than one cycle per command.

Test Plan:
- Read x5 (regfile holds 0x1234_5678), halted_i tied 1 -> resp_valid_o at cycle 3, resp_data_o=0x1234_5678, resp_err_o=0, jtag_we_o never 1.
- Write x7=0xDEAD_BEEF, halted_i rises 4 cycles after accept -> one jtag_we_o pulse with addr 7, data 0xDEAD_BEEF; resp_data_o=0xDEAD_BEEF, err 0.
- Write x3 with core_we_i held 1 for 3 cycles in ACCESS -> jtag_we_o stays 0 for 3 cycles, pulses once after; verify passes.
- Write x9=0xA5A5_A5A5 with the regfile model forcing a read-back of 0 -> resp_err_o=1, resp_data_o=0.
- halted_i never asserted, HALT_TIMEOUT=255 -> resp_valid_o with err=1, data=0 after 255 HALT_WAIT cycles; no jtag_we_o; halt_req_o drops after handshake.
- Write x0, and separately assert rst mid-HALT_WAIT -> x0: no jtag_we_o, resp data 0, err 0. rst: all outputs 0 immediately, req_ready_o=1, no response issued.
